// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV32I byte/half/word load-store sequencer for a sync word RAM
// Optional LSU_MISALIGN_TRAP_EN makes misaligned H/HU/W accesses illegal.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int AW = 5
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        ramR,
  output logic        ramW,
  output logic [31:0] ramAddr,
  output logic [31:0] ramDataW,
  input  logic [31:0] ramDataR
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    CAP  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic        w_accept;
  logic        w_illegal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loaded;
  logic [31:0] w_merged;
  logic        w_unused;

  assign w_accept = (r_state == IDLE) && req;
  assign w_unused = ^addr[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (we && funct3[2]) ||
                     ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
  assign w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (we && funct3[2]);
`endif

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    ramR        = (r_state == RD);
    ramW        = (r_state == WR);
    case (r_state)
      IDLE: if (req) begin
        if (w_illegal)                     w_state_nxt = ERR;
        else if (we && funct3 == 3'b010)   w_state_nxt = WR;
        else                               w_state_nxt = RD;
      end
      RD:      w_state_nxt = r_we ? MRG : CAP;
      MRG:     w_state_nxt = WR;
      WR:      w_state_nxt = IDLE;
      CAP:     w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Words and halves ignore the low offset bits unless the trap build rejects them.
  always_comb begin
    w_byte   = ramDataR[{r_off, 3'b000} +: 8];
    w_half   = r_off[1] ? ramDataR[31:16] : ramDataR[15:0];
    w_loaded = ramDataR;
    case (r_funct3[1:0])
      2'b00:   w_loaded = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   w_loaded = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_loaded = ramDataR;
    endcase
  end

  always_comb begin
    w_merged = ramDataR;
    if (r_funct3[1:0] == 2'b00) w_merged[{r_off, 3'b000} +: 8]   = r_wdata[7:0];
    else                        w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'd0;
      ramAddr  <= 32'd0;
      ramDataW <= 32'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_wdata  <= 16'd0;
    end else begin
      done <= (r_state == WR) || (r_state == CAP) || (r_state == ERR);
      err  <= (r_state == ERR);
      if (w_accept) begin
        r_we     <= we;
        r_funct3 <= funct3;
        r_off    <= addr[1:0];
        r_wdata  <= wdata[15:0];
        ramAddr  <= {{(32-AW){1'b0}}, addr[AW+1:2]};
        if (we) ramDataW <= wdata;
      end
      if (r_state == MRG) ramDataW <= w_merged;
      if (r_state == CAP) rdata    <= w_loaded;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural sync word RAM and
// a scoreboard queue of expected completions.
`default_nettype none

module tb_load_store_unit;

  logic        clock;
  logic        nReset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        ramR;
  logic        ramW;
  logic [31:0] ramAddr;
  logic [31:0] ramDataW;
  logic [31:0] ramDataR;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:31];
  logic [31:0] last_rdata;
  logic [31:0] last_waddr;
  int          rd_cnt;
  int          wr_cnt;
  int          overlap_cnt;
  int          tests;
  int          fails;

  load_store_unit #(.AW(5)) dut (
    .clock    (clock),
    .nReset   (nReset),
    .req      (req),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .ramR     (ramR),
    .ramW     (ramW),
    .ramAddr  (ramAddr),
    .ramDataW (ramDataW),
    .ramDataR (ramDataR)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural synchronous word RAM plus strobe monitor
  always @(posedge clock) begin
    if (ramW) begin
      mem[ramAddr[4:0]] <= ramDataW;
      wr_cnt     = wr_cnt + 1;
      last_waddr = ramAddr;
    end
    if (ramR) begin
      ramDataR <= mem[ramAddr[4:0]];
      rd_cnt   = rd_cnt + 1;
    end
    if (ramR && ramW) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the unit idle (or in its done cycle); returns
  // at the negedge of the done cycle so the next call is back-to-back.
  task automatic access(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int exp_nr, input int exp_nw);
    exp_t e;
    int   edges;
    int   r0;
    int   w0;
    e.err   = exp_err;
    e.rdata = (exp_err || w) ? last_rdata : exp_rd;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    last_rdata = e.rdata;
    r0 = rd_cnt;
    w0 = wr_cnt;
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(negedge clock);
    req = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 16) begin
      @(negedge clock);
      edges++;
    end
    e = sb_q.pop_front();
    check({tag, " latency"}, edges, e.lat);
    check({tag, " err"}, {31'd0, err}, {31'd0, e.err});
    check({tag, " rdata"}, rdata, e.rdata);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    check({tag, " ramR count"}, rd_cnt - r0, exp_nr);
    check({tag, " ramW count"}, wr_cnt - w0, exp_nw);
  endtask

  initial begin
    int w_before;
    tests = 0; fails = 0;
    rd_cnt = 0; wr_cnt = 0; overlap_cnt = 0;
    last_rdata = 32'd0; last_waddr = 32'd0;
    ramDataR = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    nReset = 1'b0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset ramR/ramW", {30'd0, ramR, ramW}, 32'd0);
    check("reset ramAddr", ramAddr, 32'd0);
    check("reset ramDataW", ramDataW, 32'd0);
    check("reset rdata", rdata, 32'd0);
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    @(negedge clock);

    access("SW 0x08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 1, 0, 1);
    check("SW word index", last_waddr, 32'd2);
    access("LW 0x08", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0);
    access("LB 0x0B", 1'b0, 3'b000, 32'h0B, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 1, 0);
    access("LBU 0x0B", 1'b0, 3'b100, 32'h0B, 32'h0, 1'b0, 32'h000000DE, 2, 1, 0);
    access("LH 0x08", 1'b0, 3'b001, 32'h08, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1, 0);
    access("LHU 0x0A", 1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 32'h0000DEAD, 2, 1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    access("LH 0x09 trap", 1'b0, 3'b001, 32'h09, 32'h0, 1'b1, 32'h0, 1, 0, 0);
`else
    access("LH 0x09", 1'b0, 3'b001, 32'h09, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1, 0);
`endif
    access("SB 0x09", 1'b1, 3'b000, 32'h09, 32'h12, 1'b0, 32'h0, 3, 1, 1);
    access("LW after SB", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD12EF, 2, 1, 0);
    access("SW 0x10", 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 32'h0, 1, 0, 1);
    access("SH 0x12", 1'b1, 3'b001, 32'h12, 32'hFFFFABCD, 1'b0, 32'h0, 3, 1, 1);
    access("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hABCD3344, 2, 1, 0);
    access("LB 0x10", 1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'h00000044, 2, 1, 0);
    access("LH 0x12", 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFABCD, 2, 1, 0);
    access("store f3=100", 1'b1, 3'b100, 32'h08, 32'h55, 1'b1, 32'h0, 1, 0, 0);
    access("load f3=011", 1'b0, 3'b011, 32'h08, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    access("load f3=111", 1'b0, 3'b111, 32'h08, 32'h0, 1'b1, 32'h0, 1, 0, 0);

    // Reset asserted while an SB sits in MRG must drop the write entirely.
    w_before = wr_cnt;
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h08; wdata = 32'h34;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    nReset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ramW", {31'd0, ramW}, 32'd0);
    check("abort rdata", rdata, 32'd0);
    last_rdata = 32'd0;
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    repeat (5) @(negedge clock);
    check("no ramW after abort", wr_cnt - w_before, 0);
    access("LW after abort", 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEAD12EF, 2, 1, 0);

    check("ramR/ramW overlap", overlap_cnt, 0);
    check("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
